timer_irq_ctrl: RTL

Control and interrupt-delivery stage for the position timer. It sits downstream of `clk_interruptor`: it consumes `int_0` and turns it into a latched, acknowledgeable `irq` for the controller. It also closes the loop upstream by driving `clk_counter` (`en`, `rst`) and `clk_interruptor` (`en`, `limit`), so the counter/comparator pair runs in one-shot or periodic mode without controller intervention.

---
 rtl/timer_pkg.sv | 40 ++++
 rtl/timer_irq_ctrl_rise_detect.sv | 33 +++
 rtl/timer_irq_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the position-timer control stage.
//   state_t        : controller FSM states (IDLE, ARM, RUN, DONE)
//   DEF_CNT_W      : default width of the limit / count path
//   DEF_EVT_W      : default width of the event counter
//   MODE_ONESHOT   : stop in DONE after the first event
//   MODE_PERIODIC  : re-arm the counter after every event
// ----------------------------------------------------------------------------
package timer_pkg;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_EVT_W = 16;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // While the counter is held in reset the edge history is meaningless, so
    // it is cleared in these states; a level that is already high when RUN is
    // entered then counts as a fresh edge.
    function automatic logic edge_hist_clear(input state_t st);
        logic clr;
        case (st)
            ST_IDLE: clr = 1'b1;
            ST_ARM:  clr = 1'b1;
            ST_RUN:  clr = 1'b0;
            ST_DONE: clr = 1'b0;
            default: clr = 1'b1;
        endcase
        return clr;
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector with synchronous clear.
//   clk  : system clock
//   rst  : synchronous active-high reset (history -> 0)
//   clr  : synchronous clear of the history register
//   din  : level input
//   rise : din is high now and was low (or cleared) on the previous cycle
// ----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic rise
);

    logic din_q_r;

    // Previous-cycle copy of din, forced low while clr is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q_r <= 1'b0;
        end else if (clr) begin
            din_q_r <= 1'b0;
        end else begin
            din_q_r <= din;
        end
    end

    assign rise = din & ~din_q_r;

endmodule

// File: rtl/timer_irq_ctrl.sv
// ----------------------------------------------------------------------------
// timer_irq_ctrl
// Runs the upstream counter/comparator pair in one-shot or periodic mode and
// converts comparator events into a sticky, acknowledgeable interrupt.
//   clk, rst      : clock, synchronous active-high reset
//   cfg_en        : run request (level)
//   cfg_periodic  : 1 = restart after each event, 0 = one-shot
//   cfg_limit     : terminal count, latched on start
//   int_0         : comparator level, event on its rising edge in RUN
//   irq_ack       : single-cycle interrupt acknowledge
//   cnt_en/cnt_rst: counter enable / reset
//   intr_en       : comparator enable
//   limit         : latched terminal count for the comparator
//   irq           : pending interrupt (sticky until acked)
//   overrun       : event arrived while irq was already pending (sticky)
//   event_cnt     : saturating count of events since the last start
//   cfg_err       : start rejected because cfg_limit was zero
// All outputs are registered.
// ----------------------------------------------------------------------------
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int EVT_W = DEF_EVT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             cfg_periodic,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             int_0,
    input  logic             irq_ack,
    output logic             cnt_en,
    output logic             cnt_rst,
    output logic             intr_en,
    output logic [CNT_W-1:0] limit,
    output logic             irq,
    output logic             overrun,
    output logic [EVT_W-1:0] event_cnt,
    output logic             cfg_err
);

    localparam logic [EVT_W-1:0] EVT_MAX = {EVT_W{1'b1}};
    localparam logic [EVT_W-1:0] EVT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LIM_ZERO = {CNT_W{1'b0}};

    state_t state_r;
    state_t state_nxt_s;
    logic   mode_r;

    logic   rise_s;
    logic   event_s;
    logic   start_ok_s;
    logic   start_bad_s;
    logic   cnt_en_nxt_s;
    logic   cnt_rst_nxt_s;

    rise_detect u_int0_rise (
        .clk  (clk),
        .rst  (rst),
        .clr  (edge_hist_clear(state_r)),
        .din  (int_0),
        .rise (rise_s)
    );

    assign event_s     = rise_s & (state_r == ST_RUN);
    assign start_ok_s  = (state_r == ST_IDLE) & cfg_en & (cfg_limit != LIM_ZERO);
    assign start_bad_s = (state_r == ST_IDLE) & cfg_en & (cfg_limit == LIM_ZERO);

    // Next-state selection; dropping cfg_en wins over an event in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!cfg_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cfg_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (event_s) begin
                    if (mode_r == MODE_PERIODIC) begin
                        state_nxt_s = ST_ARM;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!cfg_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter control decoded from the upcoming state so it can be registered
    // and still line up with the state it belongs to.
    always_comb begin
        cnt_en_nxt_s  = 1'b0;
        cnt_rst_nxt_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE: begin
                cnt_en_nxt_s  = 1'b0;
                cnt_rst_nxt_s = 1'b1;
            end
            ST_ARM: begin
                cnt_en_nxt_s  = 1'b0;
                cnt_rst_nxt_s = 1'b1;
            end
            ST_RUN: begin
                cnt_en_nxt_s  = 1'b1;
                cnt_rst_nxt_s = 1'b0;
            end
            ST_DONE: begin
                cnt_en_nxt_s  = 1'b0;
                cnt_rst_nxt_s = 1'b0;
            end
            default: begin
                cnt_en_nxt_s  = 1'b0;
                cnt_rst_nxt_s = 1'b1;
            end
        endcase
    end

    // State register and registered counter/comparator controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_en  <= 1'b0;
            cnt_rst <= 1'b1;
            intr_en <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_en  <= cnt_en_nxt_s;
            cnt_rst <= cnt_rst_nxt_s;
            intr_en <= cnt_en_nxt_s;
        end
    end

    // Configuration captured on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            limit  <= LIM_ZERO;
            mode_r <= MODE_ONESHOT;
        end else if (start_ok_s) begin
            limit  <= cfg_limit;
            mode_r <= cfg_periodic;
        end else begin
            limit  <= limit;
            mode_r <= mode_r;
        end
    end

    // Configuration error flag: set on a zero-limit start, cleared by a good one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (start_bad_s) begin
            cfg_err <= 1'b1;
        end else if (start_ok_s) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_err;
        end
    end

    // Pending interrupt: an event wins over a simultaneous acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (event_s) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end else begin
            irq <= irq;
        end
    end

    // Overrun: an event lands on an interrupt that is still pending and is
    // not being acknowledged in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (start_ok_s) begin
            overrun <= 1'b0;
        end else if (event_s && irq && !irq_ack) begin
            overrun <= 1'b1;
        end else begin
            overrun <= overrun;
        end
    end

    // Saturating event counter, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            event_cnt <= {EVT_W{1'b0}};
        end else if (start_ok_s) begin
            event_cnt <= {EVT_W{1'b0}};
        end else if (event_s && (event_cnt != EVT_MAX)) begin
            event_cnt <= event_cnt + EVT_ONE;
        end else begin
            event_cnt <= event_cnt;
        end
    end

endmodule
